// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO burst-drain block and its output skid buffer.
package fifo_drain_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned CNT_W        = 5;
  localparam int unsigned MAX_DATA_DEF = 16;
  localparam int unsigned TIMEOUT_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // One stream word as held in the skid buffer.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } word_t;

  // Requested burst length clamped to [1, max_len].
  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] req,
                                               input logic [CNT_W-1:0] max_len);
    logic [CNT_W-1:0] len;
    if (req == '0) begin
      len = CNT_W'(1);
    end else if (req > max_len) begin
      len = max_len;
    end else begin
      len = req;
    end
    return len;
  endfunction

endpackage

// File: rtl/fifo_drain_if.sv
// FIFO read port plus output stream; master = the drain engine, slave = FIFO/sink side.
interface fifo_drain_if;
  import fifo_drain_pkg::*;

  logic [CNT_W-1:0]  count;
  logic              empty;
  logic [DATA_W-1:0] rdata;
  logic              ren;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    input  count, empty, rdata, out_ready,
    output ren, out_valid, out_data, out_last
  );

  modport slave (
    output count, empty, rdata, out_ready,
    input  ren, out_valid, out_data, out_last
  );

endinterface

// File: rtl/fifo_drain_skid2.sv
// Two-entry output skid buffer: words pushed from FIFO read data, head entry drives the stream.
module stream_skid2
  import fifo_drain_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic [1:0]        occ_o
);

  logic [1:0] occ_q, occ_d;
  word_t      head_q, head_d;
  word_t      tail_q, tail_d;
  word_t      in_w;
  logic       pop;

  always_comb begin
    in_w      = '0;
    in_w.data = data_i;
    in_w.last = last_i;
    pop       = (occ_q != 2'd0) && ready_i;
    occ_d     = occ_q;
    head_d    = head_q;
    tail_d    = tail_q;
    unique case ({push_i, pop})
      2'b01: begin
        occ_d = occ_q - 2'd1;
        if (occ_q == 2'd2) head_d = tail_q;
      end
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) head_d = in_w;
        else               tail_d = in_w;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = in_w;
        end else begin
          head_d = tail_q;
          tail_d = in_w;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign data_o  = head_q.data;
  assign last_o  = head_q.last;
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_drain.sv
// Drains a FIFO in bursts (full, flush-forced or timeout-forced) into a ready/valid stream.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned MAX_DATA = MAX_DATA_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             flush,
  output logic             busy,
  fifo_drain_if.master     bus
);

  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_DATA);
  localparam int unsigned      TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             flush_pend_q, flush_pend_d;
  logic             inflight_q;
  logic             infl_last_q, infl_last_d;
  logic             busy_q;

  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] part_len;
  logic [1:0]       skid_occ;
  logic             pop;
  logic             room_ok;
  logic             ren_c;
  logic             flush_now;

  // Read issue: combinational so it always sees the current empty flag.
  always_comb begin
    len_eff     = eff_len(burst_len, MAX_W);
    part_len    = (bus.count > MAX_W) ? MAX_W : bus.count;
    pop         = bus.out_valid && bus.out_ready;
    room_ok     = ({1'b0, skid_occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    ren_c       = (state_q == ST_BURST) && !bus.empty && (rd_cnt_q < n_q) && room_ok;
    infl_last_d = ren_c && (rd_cnt_q == n_q - CNT_W'(1));
  end

  assign bus.ren = ren_c;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    rd_cnt_d     = rd_cnt_q;
    tmo_d        = '0;
    flush_pend_d = flush_pend_q;
    flush_now    = flush || flush_pend_q;
    unique case (state_q)
      ST_IDLE: begin
        rd_cnt_d = '0;
        if (flush_now && (bus.count == '0)) begin
          flush_pend_d = 1'b0;
        end
        if (flush_now && (bus.count != '0)) begin
          state_d      = ST_BURST;
          n_d          = part_len;
          flush_pend_d = 1'b0;
        end else if (bus.count >= len_eff) begin
          state_d = ST_BURST;
          n_d     = len_eff;
        end else if (bus.count != '0) begin
          // Partial FIFO: wait out the timeout, then send what is there.
          if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = ST_BURST;
            n_d     = part_len;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      ST_BURST: begin
        if (flush) flush_pend_d = 1'b1;
        if (ren_c) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          if (rd_cnt_q == n_q - CNT_W'(1)) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (flush) flush_pend_d = 1'b1;
        if (pop && bus.out_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      rd_cnt_q     <= '0;
      tmo_q        <= '0;
      flush_pend_q <= 1'b0;
      inflight_q   <= 1'b0;
      infl_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      rd_cnt_q     <= rd_cnt_d;
      tmo_q        <= tmo_d;
      flush_pend_q <= flush_pend_d;
      inflight_q   <= ren_c;
      infl_last_q  <= infl_last_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign busy = busy_q;

  // Read data arrives the cycle after ren and is captured at that cycle's closing edge.
  stream_skid2 u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .data_i  (bus.rdata),
    .last_i  (infl_last_q),
    .ready_i (bus.out_ready),
    .valid_o (bus.out_valid),
    .data_o  (bus.out_data),
    .last_o  (bus.out_last),
    .occ_o   (skid_occ)
  );

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: queue-based FIFO model, burst-chunk reference model, stream monitors.
module tb_fifo_drain;
  import fifo_drain_pkg::*;

  localparam int unsigned MAXD = 16;
  localparam int unsigned TMO  = 32;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } exp_t;
  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] burst_len;
  logic       flush;
  logic       busy;

  fifo_drain_if bus();

  fifo_drain #(.MAX_DATA(MAXD), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .burst_len (burst_len),
    .flush     (flush),
    .busy      (busy),
    .bus       (bus)
  );

  initial forever #5 clk = ~clk;

  int         n_assert, n_fail, cyc_n;
  byte_q_t    fifo_q, wr_q;
  exp_t       exp_q[$];
  bit         ren_prev, rst_req, flush_req, prev_stall, ren_s, pop_s;
  logic [7:0] prev_data;
  logic       prev_last;
  int         rdy_mode, reads_tot, acc_tot;
  int         load_cyc, first_ren, last_ren, ren_cnt, first_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply FIFO effects and inputs at negedge, then sample and check.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    cyc_n++;
    if (ren_prev && fifo_q.size() > 0) bus.rdata = fifo_q.pop_front();
    if (wr_q.size() > 0) begin
      load_cyc = cyc_n;
      while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
    end
    bus.count = 5'(fifo_q.size());
    bus.empty = (fifo_q.size() == 0);
    rst_n     = !rst_req;
    flush     = flush_req;
    flush_req = 1'b0;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = !bus.out_ready;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    ren_s = bus.ren;
    pop_s = bus.out_valid && bus.out_ready;
    chk("ren_while_empty", 32'(ren_s && bus.empty), 32'(0));
    if (prev_stall) begin
      chk("hold_valid", 32'(bus.out_valid), 32'(1));
      chk("hold_data", 32'(bus.out_data), 32'(prev_data));
      chk("hold_last", 32'(bus.out_last), 32'(prev_last));
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_last  = bus.out_last;
    if (ren_s) begin
      reads_tot++;
      ren_cnt++;
      if (first_ren < 0) first_ren = cyc_n;
      last_ren = cyc_n;
    end
    if (bus.out_valid && first_valid < 0) first_valid = cyc_n;
    if (pop_s) begin
      acc_tot++;
      chk("word_expected", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.data));
        chk("out_last", 32'(bus.out_last), 32'(e.last));
      end
    end
    chk("skid_bound", 32'((reads_tot - acc_tot) <= 2), 32'(1));
    ren_prev = ren_s;
  endtask

  function automatic int eff_l();
    int bl;
    bl = int'(burst_len);
    return (bl == 0) ? 1 : ((bl > int'(MAXD)) ? int'(MAXD) : bl);
  endfunction

  // Words already in an idle FIFO leave as full bursts of L, then one partial burst.
  task automatic add_chunks(input byte_q_t w, input int l);
    int idx;
    int rem;
    int n;
    exp_t e;
    idx = 0;
    rem = w.size();
    while (rem > 0) begin
      n = (rem >= l) ? l : rem;
      for (int k = 0; k < n; k++) begin
        e.data = w[idx];
        e.last = (k == n - 1);
        exp_q.push_back(e);
        idx++;
      end
      rem -= n;
    end
  endtask

  task automatic load(input int n, input bit fixed, input logic [7:0] base);
    byte_q_t w;
    for (int i = 0; i < n; i++) w.push_back(fixed ? base + 8'(i) : 8'($urandom));
    add_chunks(w, eff_l());
    foreach (w[i]) wr_q.push_back(w[i]);
  endtask

  task automatic mark();
    first_ren   = -1;
    last_ren    = -1;
    first_valid = -1;
    ren_cnt     = 0;
  endtask

  task automatic drain(input string tag);
    int b;
    b = 0;
    while (!(exp_q.size() == 0 && !busy && fifo_q.size() == 0) && b < 800) begin
      cyc();
      b++;
    end
    chk({tag, "_drained"}, 32'(b < 800), 32'(1));
  endtask

  task automatic wait_acc(input int target, input string tag);
    int b;
    b = 0;
    while (acc_tot < target && b < 300) begin
      cyc();
      b++;
    end
    chk({tag, "_accepts"}, 32'(acc_tot >= target), 32'(1));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ren"}, 32'(bus.ren), 32'(0));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
    chk({tag, "_out_data"}, 32'(bus.out_data), 32'(0));
    chk({tag, "_out_last"}, 32'(bus.out_last), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int base;
    int a;
    int gap;
    n_assert = 0; n_fail = 0; cyc_n = 0;
    rst_n = 1'b0; rst_req = 1'b1; flush = 1'b0; flush_req = 1'b0; burst_len = 5'd4;
    bus.count = '0; bus.empty = 1'b1; bus.rdata = '0; bus.out_ready = 1'b0;
    ren_prev = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    rdy_mode = 0; reads_tot = 0; acc_tot = 0; load_cyc = 0;
    mark();

    cyc();
    chk_rst("por");
    cyc();
    rst_req = 1'b0;
    cyc();
    chk("por_release_busy", 32'(busy), 32'(0));

    // Full 4-word burst, sink always ready.
    burst_len = 5'd4; rdy_mode = 0; mark();
    load(4, 1'b1, 8'h11);
    drain("b4");
    chk("b4_first_ren", 32'(first_ren), 32'(load_cyc + 1));
    chk("b4_ren_count", 32'(ren_cnt), 32'(4));
    chk("b4_ren_span", 32'(last_ren - first_ren), 32'(3));
    chk("b4_valid_latency", 32'(first_valid - first_ren), 32'(2));
    chk("b4_busy_after", 32'(busy), 32'(0));

    // Partial FIFO waits for the timeout.
    burst_len = 5'd8; mark();
    load(3, 1'b0, 8'h00);
    drain("tmo");
    chk("tmo_first_ren", 32'(first_ren - load_cyc), 32'(TMO));
    chk("tmo_ren_count", 32'(ren_cnt), 32'(3));

    // Backpressure toggling; 2 words left behind after the first burst.
    burst_len = 5'd4; rdy_mode = 1; mark(); base = acc_tot;
    load(6, 1'b0, 8'h00);
    wait_acc(base + 4, "bp");
    cyc();
    chk("bp_left_count", 32'(bus.count), 32'(2));
    chk("bp_idle", 32'(busy), 32'(0));
    drain("bp");

    // Flush while busy: leftovers go out right after returning to idle.
    rdy_mode = 0; mark(); base = acc_tot;
    load(6, 1'b0, 8'h00);
    a = 0;
    while (!busy && a < 20) begin cyc(); a++; end
    chk("fl_went_busy", 32'(busy), 32'(1));
    flush_req = 1'b1;
    wait_acc(base + 4, "fl");
    a = cyc_n; gap = 0;
    do begin cyc(); gap++; end while (!ren_s && gap < 100);
    chk("fl_restart_gap", 32'(cyc_n - a), 32'(2));
    drain("fl");

    // Flush with an empty FIFO is dropped: no activity, and a later word waits for timeout.
    mark(); flush_req = 1'b1;
    repeat (40) cyc();
    chk("fl0_no_ren", 32'(ren_cnt), 32'(0));
    chk("fl0_idle", 32'(busy), 32'(0));
    load(1, 1'b0, 8'h00);
    drain("fl0");
    chk("fl0_first_ren", 32'(first_ren - load_cyc), 32'(TMO));

    // Length clamping: zero gives single-word bursts, oversize gives MAX_DATA.
    burst_len = 5'd0; mark();
    load(3, 1'b0, 8'h00);
    drain("len0");
    chk("len0_ren_count", 32'(ren_cnt), 32'(3));
    burst_len = 5'd31; mark();
    load(16, 1'b0, 8'h00);
    drain("len31");
    chk("len31_ren_count", 32'(ren_cnt), 32'(16));
    chk("len31_sustained", 32'(last_ren - first_ren), 32'(15));

    // Randomised lengths, sizes and sink behaviour.
    for (int it = 0; it < 10; it++) begin
      burst_len = 5'($urandom_range(0, 31));
      rdy_mode  = int'($urandom_range(0, 2));
      mark();
      load(int'($urandom_range(1, 16)), 1'b0, 8'h00);
      drain("rnd");
    end

    // Reset mid-burst after 2 words: in-flight words are lost, FIFO remainder drains later.
    burst_len = 5'd4; rdy_mode = 0; mark(); base = acc_tot;
    load(6, 1'b0, 8'h00);
    wait_acc(base + 2, "rst");
    rst_req = 1'b1;
    cyc();
    chk_rst("mid_rst");
    rst_req = 1'b0;
    exp_q.delete();
    add_chunks(fifo_q, eff_l());
    reads_tot = acc_tot;
    cyc();
    chk("rst_release_busy", 32'(busy), 32'(0));
    chk("rst_release_ren", 32'(ren_s), 32'(0));
    drain("rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
